// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 25 MHz pixel-enable VGA timing generator with registered syncs and frame pulse
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pixel_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       h_sync,
    output logic       v_sync,
    output logic       video_on,
    output logic       frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT = 10'(V_ACTIVE);
    localparam logic [9:0] H_SS  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SE  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_SS  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SE  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
            $error("vga_sync_gen: H_TOTAL/V_TOTAL must fit 10-bit counters");
        end
    endgenerate

    logic [1:0] r_pre;
    logic [9:0] r_x, r_y;
    logic       r_hs, r_vs, r_von, r_fs;
    logic       w_tick, w_h_end, w_v_end;

    assign w_tick  = r_pre == 2'd3;
    assign w_h_end = r_x == H_MAX;
    assign w_v_end = r_y == V_MAX;

    // syncs, video_on and frame_start are decoded from the pre-edge counters, so they lag by one clk
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre <= '0;
            r_x   <= '0;
            r_y   <= '0;
            r_hs  <= 1'b1;
            r_vs  <= 1'b1;
            r_von <= 1'b0;
            r_fs  <= 1'b0;
        end else begin
            r_pre <= r_pre + 2'd1;
            if (w_tick) begin
                r_x <= w_h_end ? '0 : r_x + 10'd1;
                if (w_h_end)
                    r_y <= w_v_end ? '0 : r_y + 10'd1;
            end
            r_hs  <= !(r_x >= H_SS && r_x <= H_SE);
            r_vs  <= !(r_y >= V_SS && r_y <= V_SE);
            r_von <= r_x < H_ACT && r_y < V_ACT;
            r_fs  <= w_tick && w_h_end && w_v_end;
        end
    end

    assign pixel_tick  = w_tick;
    assign pixel_x     = r_x;
    assign pixel_y     = r_y;
    assign h_sync      = r_hs;
    assign v_sync      = r_vs;
    assign video_on    = r_von;
    assign frame_start = r_fs;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of default-line timing and small-parameter frame timing
module tb_vga_sync_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_d, rst_s;
    logic       d_tick, d_hs, d_vs, d_von, d_fs;
    logic [9:0] d_x, d_y;
    logic       s_tick, s_hs, s_vs, s_von, s_fs;
    logic [9:0] s_x, s_y;
    int tests = 0;
    int fails = 0;

    vga_sync_gen dut (
        .clk(clk), .reset(rst_d), .pixel_tick(d_tick), .pixel_x(d_x), .pixel_y(d_y),
        .h_sync(d_hs), .v_sync(d_vs), .video_on(d_von), .frame_start(d_fs)
    );

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut_s (
        .clk(clk), .reset(rst_s), .pixel_tick(s_tick), .pixel_x(s_x), .pixel_y(s_y),
        .h_sync(s_hs), .v_sync(s_vs), .video_on(s_von), .frame_start(s_fs)
    );

    task automatic test_reset();
        rst_d = 1'b1;
        rst_s = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (d_tick !== 1'b0) begin fails++; $display("FAIL reset_tick: got %b want 0", d_tick); end
        tests++; if (d_x !== 10'd0) begin fails++; $display("FAIL reset_x: got %0d want 0", d_x); end
        tests++; if (d_y !== 10'd0) begin fails++; $display("FAIL reset_y: got %0d want 0", d_y); end
        tests++; if (d_hs !== 1'b1) begin fails++; $display("FAIL reset_hs: got %b want 1", d_hs); end
        tests++; if (d_vs !== 1'b1) begin fails++; $display("FAIL reset_vs: got %b want 1", d_vs); end
        tests++; if (d_von !== 1'b0) begin fails++; $display("FAIL reset_von: got %b want 0", d_von); end
        tests++; if (d_fs !== 1'b0) begin fails++; $display("FAIL reset_fs: got %b want 0", d_fs); end
    endtask

    task automatic test_restart_d();
        rst_d = 1'b0;
        @(negedge clk);
        tests++; if ({d_von, d_tick, d_x} !== {1'b1, 1'b0, 10'd0}) begin fails++; $display("FAIL restart_d_edge1: got von/tick/x %b/%b/%0d want 1/0/0", d_von, d_tick, d_x); end
        repeat (2) @(negedge clk);
        tests++; if ({d_tick, d_x} !== {1'b1, 10'd0}) begin fails++; $display("FAIL restart_d_cycle4: got tick/x %b/%0d want 1/0", d_tick, d_x); end
        @(negedge clk);
        tests++; if ({d_tick, d_x, d_y} !== {1'b0, 10'd1, 10'd0}) begin fails++; $display("FAIL restart_d_edge4: got tick/x/y %b/%0d/%0d want 0/1/0", d_tick, d_x, d_y); end
    endtask

    task automatic test_line_d();
        int last_tick = -1, tick_bad = 0, x656 = -1, hs_fall = -1, hs_run = 0, hs_len = -1;
        int von1 = 0, over = 0;
        int ls[$];
        logic [9:0] px, py;
        px = d_x;
        py = d_y;
        for (int i = 0; i < 7000; i++) begin
            @(negedge clk);
            if (d_tick) begin
                if (last_tick >= 0 && i - last_tick != 4) tick_bad++;
                last_tick = i;
            end
            if (d_x == 0 && px != 0) ls.push_back(i);
            if (d_x == 656 && px != 656 && x656 < 0) x656 = i;
            if (!d_hs) begin
                if (hs_run == 0 && hs_fall < 0) hs_fall = i;
                hs_run++;
            end else begin
                if (hs_run > 0 && hs_len < 0) hs_len = hs_run;
                hs_run = 0;
            end
            if (d_von && py == 1) von1++;
            if (d_x > 799 || d_y > 524) over++;
            px = d_x;
            py = d_y;
        end
        tests++; if (tick_bad != 0 || last_tick < 0) begin fails++; $display("FAIL tick_period: got %0d bad periods want 0", tick_bad); end
        tests++; if (ls.size() < 2) begin fails++; $display("FAIL line_starts: got %0d want >=2", ls.size()); end
        else begin
            tests++; if (ls[1] - ls[0] != 3200) begin fails++; $display("FAIL line_period: got %0d want 3200", ls[1] - ls[0]); end
        end
        tests++; if (hs_len != 384) begin fails++; $display("FAIL hsync_len: got %0d want 384", hs_len); end
        tests++; if (x656 < 0 || hs_fall != x656 + 1) begin fails++; $display("FAIL hsync_start: got %0d want %0d", hs_fall, x656 + 1); end
        tests++; if (von1 != 2560) begin fails++; $display("FAIL video_on_line1: got %0d want 2560", von1); end
        tests++; if (over != 0) begin fails++; $display("FAIL counter_range: got %0d overflows want 0", over); end
        tests++; if (d_fs !== 1'b0) begin fails++; $display("FAIL no_early_fs: got %b want 0", d_fs); end
        tests++; if ({s_tick, s_x, s_y, s_hs, s_vs, s_von, s_fs} !== {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            fails++; $display("FAIL reset_hold_s: got %b want all-reset", {s_tick, s_x, s_y, s_hs, s_vs, s_von, s_fs});
        end
    endtask

    task automatic test_frame_s();
        int fs_idx[$], lines[$];
        int fs_wide = 0, hs_bad = 0, von_bad = 0, vs_bad = 0, wrap_bad = 0, wrap_seen = 0;
        int y5 = -1, vs_fall = -1, vs_run = 0, vs_len = -1;
        logic [9:0] px, py;
        logic pfs, exp_b;
        px = 10'd0;
        py = 10'd0;
        pfs = 1'b0;
        rst_s = 1'b0;
        for (int i = 1; i <= 1100; i++) begin
            @(negedge clk);
            if (s_fs) fs_idx.push_back(i);
            if (s_fs && pfs) fs_wide++;
            if (s_x == 0 && px == 11) lines.push_back(i);
            exp_b = !(px >= 9 && px <= 10);
            if (s_hs !== exp_b) hs_bad++;
            exp_b = px < 8 && py < 4;
            if (s_von !== exp_b) von_bad++;
            exp_b = py != 5;
            if (s_vs !== exp_b) vs_bad++;
            if (s_y == 5 && py != 5 && y5 < 0) y5 = i;
            if (!s_vs) begin
                if (vs_run == 0 && vs_fall < 0) vs_fall = i;
                vs_run++;
            end else begin
                if (vs_run > 0 && vs_len < 0) vs_len = vs_run;
                vs_run = 0;
            end
            if (px == 11 && py == 6 && (s_x != px || s_y != py)) begin
                if (s_x == 0 && s_y == 0) wrap_seen++;
                else wrap_bad++;
            end
            if (s_y != py && !(px == 11 && s_x == 0)) wrap_bad++;
            if (s_x > 11 || s_y > 6) wrap_bad++;
            px = s_x;
            py = s_y;
            pfs = s_fs;
        end
        tests++; if (fs_idx.size() != 3) begin fails++; $display("FAIL fs_count: got %0d want 3", fs_idx.size()); end
        else begin
            tests++; if (fs_idx[0] != 336) begin fails++; $display("FAIL fs_first: got %0d want 336", fs_idx[0]); end
            tests++; if (fs_idx[1] - fs_idx[0] != 336 || fs_idx[2] - fs_idx[1] != 336) begin
                fails++; $display("FAIL frame_period: got %0d/%0d want 336", fs_idx[1] - fs_idx[0], fs_idx[2] - fs_idx[1]);
            end
        end
        tests++; if (fs_wide != 0) begin fails++; $display("FAIL fs_width: got %0d wide pulses want 0", fs_wide); end
        tests++; if (lines.size() < 2) begin fails++; $display("FAIL s_lines: got %0d want >=2", lines.size()); end
        else begin
            tests++; if (lines[1] - lines[0] != 48) begin fails++; $display("FAIL s_line_period: got %0d want 48", lines[1] - lines[0]); end
        end
        tests++; if (hs_bad != 0) begin fails++; $display("FAIL s_hsync: got %0d bad samples want 0", hs_bad); end
        tests++; if (von_bad != 0) begin fails++; $display("FAIL s_video_on: got %0d bad samples want 0", von_bad); end
        tests++; if (vs_bad != 0) begin fails++; $display("FAIL s_vsync: got %0d bad samples want 0", vs_bad); end
        tests++; if (vs_len != 48) begin fails++; $display("FAIL s_vsync_len: got %0d want 48", vs_len); end
        tests++; if (y5 < 0 || vs_fall != y5 + 1) begin fails++; $display("FAIL s_vsync_start: got %0d want %0d", vs_fall, y5 + 1); end
        tests++; if (wrap_bad != 0 || wrap_seen != 3) begin fails++; $display("FAIL s_wrap: got bad=%0d seen=%0d want 0/3", wrap_bad, wrap_seen); end
    endtask

    task automatic test_midsync_s();
        int found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            @(negedge clk);
            if (s_y == 5 && s_hs == 1'b0) found = 1;
        end
        tests++; if (found == 0) begin fails++; $display("FAIL midsync_reach: got none want y=5 with h_sync low"); end
        tests++; if (s_vs !== 1'b0) begin fails++; $display("FAIL midsync_vs_pre: got %b want 0", s_vs); end
        #1 rst_s = 1'b1;
        #1;
        tests++; if ({s_tick, s_x, s_y, s_hs, s_vs, s_von, s_fs} !== {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            fails++; $display("FAIL midsync_async: got %b want all-reset", {s_tick, s_x, s_y, s_hs, s_vs, s_von, s_fs});
        end
        @(negedge clk);
    endtask

    task automatic test_restart_s();
        rst_s = 1'b0;
        @(negedge clk);
        tests++; if ({s_von, s_tick, s_x} !== {1'b1, 1'b0, 10'd0}) begin fails++; $display("FAIL restart_s_edge1: got von/tick/x %b/%b/%0d want 1/0/0", s_von, s_tick, s_x); end
        repeat (2) @(negedge clk);
        tests++; if ({s_tick, s_x} !== {1'b1, 10'd0}) begin fails++; $display("FAIL restart_s_cycle4: got tick/x %b/%0d want 1/0", s_tick, s_x); end
        @(negedge clk);
        tests++; if ({s_tick, s_x, s_y, s_fs} !== {1'b0, 10'd1, 10'd0, 1'b0}) begin fails++; $display("FAIL restart_s_edge4: got tick/x/y/fs %b/%0d/%0d/%b want 0/1/0/0", s_tick, s_x, s_y, s_fs); end
    endtask

    initial begin
        test_reset();
        test_restart_d();
        test_line_d();
        test_frame_s();
        test_midsync_s();
        test_restart_s();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
